// File: rtl/seq_det_pkg.sv
// rtl/seq_det_pkg.sv - shared types and pattern constants for the sequence-detect arbiter
//
// Holds the arbiter FSM states, the detector states and the detected pattern.
// S<k> means the last k input bits equal the first k bits of PATTERN.

package seq_det_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } arb_state_t;

    typedef enum logic [2:0] {
        S0,
        S1,
        S2,
        S3,
        S4
    } det_state_t;

    localparam int PAT_LEN = 5;
    localparam logic [PAT_LEN-1:0] PATTERN = 5'b11011;

endpackage

// File: rtl/seq_det_arbiter_if.sv
// rtl/seq_det_arbiter_if.sv - requester/result bundle between word producers and the arbiter
//
// Signals:
//   req        per-requester request level
//   req_data   requester i word at [i*FRAME_LEN +: FRAME_LEN]
//   gnt        one-hot grant pulse, cycle after capture
//   busy       frame in flight, capture edge through done cycle
//   done       one-cycle result strobe
//   done_id    index of finished requester
//   match_cnt  saturating detection count
//   match_map  per-bit hit map (only with SEQ_DET_ARBITER_MATCH_MAP_EN)
// Modports: master = requester side, slave = arbiter side.

interface seq_det_arbiter_if #(
    parameter int N_REQ     = 4,
    parameter int FRAME_LEN = 16,
    parameter int CNT_W     = 4
);
    localparam int ID_W = $clog2(N_REQ);

    logic [N_REQ-1:0]           req;
    logic [N_REQ*FRAME_LEN-1:0] req_data;
    logic [N_REQ-1:0]           gnt;
    logic                       busy;
    logic                       done;
    logic [ID_W-1:0]            done_id;
    logic [CNT_W-1:0]           match_cnt;

`ifdef SEQ_DET_ARBITER_MATCH_MAP_EN
    logic [FRAME_LEN-1:0]       match_map;

    modport master (
        output req, req_data,
        input  gnt, busy, done, done_id, match_cnt, match_map
    );

    modport slave (
        input  req, req_data,
        output gnt, busy, done, done_id, match_cnt, match_map
    );
`else
    modport master (
        output req, req_data,
        input  gnt, busy, done, done_id, match_cnt
    );

    modport slave (
        input  req, req_data,
        output gnt, busy, done, done_id, match_cnt
    );
`endif

endinterface

// File: rtl/seq_det_core.sv
// rtl/seq_det_core.sv - overlapping Mealy detector for PATTERN (11011)
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   clr         synchronous clear to S0 (frame start), wins over en
//   en          consume din this cycle
//   din         serial input bit
//   hit         combinational: en && this bit completes the pattern

module seq_det_core
    import seq_det_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    input  logic din,
    output logic hit
);

    det_state_t state;
    det_state_t state_next;

    // On a mismatch, fall back to the longest pattern prefix that is still a
    // suffix of the bits seen; after a full match "11" is that suffix.
    always_comb begin
        state_next = state;
        hit        = 1'b0;
        if (en) begin
            case (state)
                S0: state_next = (din == PATTERN[PAT_LEN-1]) ? S1 : S0;
                S1: state_next = (din == PATTERN[3]) ? S2 : S0;
                S2: state_next = (din == PATTERN[2]) ? S3 : S2;
                S3: state_next = (din == PATTERN[1]) ? S4 : S0;
                S4: begin
                    if (din == PATTERN[0]) begin
                        hit        = 1'b1;
                        state_next = S2;
                    end else begin
                        state_next = S0;
                    end
                end
                default: state_next = S0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S0;
        end else if (clr) begin
            state <= S0;
        end else begin
            state <= state_next;
        end
    end

endmodule

// File: rtl/seq_det_arbiter.sv
// rtl/seq_det_arbiter.sv - round-robin arbiter sharing one 11011 detector among N_REQ word producers
//
// Ports:
//   clk    clock, all state changes on rising edge
//   rst_n  asynchronous active-low reset, aborts any frame in flight
//   bus    seq_det_arbiter_if.slave: req/req_data in; gnt/busy/done/done_id/match_cnt out
// Optional: SEQ_DET_ARBITER_MATCH_MAP_EN adds bus.match_map (per-bit hit map, MSB-first aligned).
//
// A captured word is shifted MSB-first through the detector, one bit per cycle;
// done reports the saturating hit count. One IDLE cycle always separates frames.

module seq_det_arbiter
    import seq_det_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int FRAME_LEN = 16,
    parameter int CNT_W     = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    seq_det_arbiter_if.slave bus
);

    localparam int ID_W = $clog2(N_REQ);
    localparam int BC_W = $clog2(FRAME_LEN);
    localparam logic [ID_W-1:0] LAST_RST = ID_W'(N_REQ - 1);
    localparam logic [BC_W-1:0] BC_LAST  = BC_W'(FRAME_LEN - 1);

    arb_state_t           state;
    logic [FRAME_LEN-1:0] shreg;
    logic [BC_W-1:0]      bit_cnt;
    logic [ID_W-1:0]      last_id;
    logic [ID_W-1:0]      done_id_q;
    logic [N_REQ-1:0]     gnt_q;
    logic                 busy_q;
    logic                 done_q;
    logic [CNT_W-1:0]     match_cnt_q;
`ifdef SEQ_DET_ARBITER_MATCH_MAP_EN
    logic [FRAME_LEN-1:0] match_map_q;
`endif

    logic [FRAME_LEN-1:0] words [N_REQ];
    logic [ID_W-1:0]      winner;
    logic [ID_W-1:0]      cand;
    logic                 found;
    logic                 capture;
    logic                 hit;

    for (genvar g = 0; g < N_REQ; g++) begin : g_words
        assign words[g] = bus.req_data[g*FRAME_LEN +: FRAME_LEN];
    end

    // Scan from the requester after the last winner, wrapping once around.
    always_comb begin
        winner = last_id;
        cand   = '0;
        found  = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = ID_W'((int'(last_id) + k) % N_REQ);
            if (!found && bus.req[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    assign capture = (state == IDLE) && (|bus.req);

    seq_det_core u_core (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (capture),
        .en    (state == SHIFT),
        .din   (shreg[FRAME_LEN-1]),
        .hit   (hit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            shreg       <= '0;
            bit_cnt     <= '0;
            last_id     <= LAST_RST;
            done_id_q   <= '0;
            gnt_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            match_cnt_q <= '0;
`ifdef SEQ_DET_ARBITER_MATCH_MAP_EN
            match_map_q <= '0;
`endif
        end else begin
            gnt_q  <= '0;
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (capture) begin
                        shreg       <= words[winner];
                        gnt_q       <= N_REQ'(1) << winner;
                        busy_q      <= 1'b1;
                        bit_cnt     <= '0;
                        match_cnt_q <= '0;
                        last_id     <= winner;
`ifdef SEQ_DET_ARBITER_MATCH_MAP_EN
                        match_map_q <= '0;
`endif
                        state       <= SHIFT;
                    end
                end
                SHIFT: begin
                    shreg   <= {shreg[FRAME_LEN-2:0], 1'b0};
                    bit_cnt <= bit_cnt + 1'b1;
                    if (hit && (match_cnt_q != '1)) begin
                        match_cnt_q <= match_cnt_q + 1'b1;
                    end
`ifdef SEQ_DET_ARBITER_MATCH_MAP_EN
                    // Map bit k lines up with frame bit k: bit_cnt 0 is the MSB.
                    if (hit) begin
                        match_map_q[BC_LAST - bit_cnt] <= 1'b1;
                    end
`endif
                    if (bit_cnt == BC_LAST) begin
                        done_q    <= 1'b1;
                        done_id_q <= last_id;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.done_id   = done_id_q;
    assign bus.match_cnt = match_cnt_q;
`ifdef SEQ_DET_ARBITER_MATCH_MAP_EN
    assign bus.match_map = match_map_q;
`endif

endmodule

// File: tb/tb_seq_det_arbiter.sv
// tb/tb_seq_det_arbiter.sv - self-checking bench for seq_det_arbiter

module tb_seq_det_arbiter;

    localparam int N_REQ     = 4;
    localparam int FRAME_LEN = 16;
    localparam int CNT_W     = 4;
    localparam int ID_W      = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    seq_det_arbiter_if #(.N_REQ(N_REQ), .FRAME_LEN(FRAME_LEN), .CNT_W(CNT_W)) bus ();
    seq_det_arbiter_if #(.N_REQ(N_REQ), .FRAME_LEN(FRAME_LEN), .CNT_W(2))     bus_sat ();

    seq_det_arbiter #(.N_REQ(N_REQ), .FRAME_LEN(FRAME_LEN), .CNT_W(CNT_W)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    seq_det_arbiter #(.N_REQ(N_REQ), .FRAME_LEN(FRAME_LEN), .CNT_W(2)) u_sat (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_sat)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int model_last;

`ifdef SEQ_DET_ARBITER_MATCH_MAP_EN
    logic [FRAME_LEN-1:0] obs_map;
`endif

    // Reference model: rotating priority and a sliding-window pattern search.
    function automatic int model_pick(input logic [N_REQ-1:0] r, input int last);
        for (int k = 1; k <= N_REQ; k++) begin
            int c;
            c = (last + k) % N_REQ;
            if (r[c]) return c;
        end
        return -1;
    endfunction

    function automatic int model_count(input logic [FRAME_LEN-1:0] w, input int cw);
        int n;
        int mx;
        logic [4:0] pat;
        pat = 5'b11011;
        n = 0;
        for (int i = FRAME_LEN - 1; i >= 4; i--) begin
            if (w[i -: 5] == pat) n++;
        end
        mx = (1 << cw) - 1;
        return (n > mx) ? mx : n;
    endfunction

    function automatic logic [FRAME_LEN-1:0] model_map(input logic [FRAME_LEN-1:0] w);
        logic [FRAME_LEN-1:0] m;
        logic [4:0] pat;
        pat = 5'b11011;
        m = '0;
        for (int i = FRAME_LEN - 1; i >= 4; i--) begin
            if (w[i -: 5] == pat) m[i-4] = 1'b1;
        end
        return m;
    endfunction

    task automatic set_word(input int i, input logic [FRAME_LEN-1:0] w);
        bus.req_data[i*FRAME_LEN +: FRAME_LEN] = w;
    endtask

    function automatic logic [FRAME_LEN-1:0] get_word(input int i);
        return bus.req_data[i*FRAME_LEN +: FRAME_LEN];
    endfunction

    // Observer only (no checks): waits for a grant, then for done, recording what it saw.
    task automatic observe_frame(input bit scramble,
                                 output logic [N_REQ-1:0] g, output int wait_n,
                                 output int lat, output logic [ID_W-1:0] id,
                                 output logic [CNT_W-1:0] cnt, output bit busy_ok);
        wait_n  = 0;
        lat     = 0;
        id      = '0;
        cnt     = '0;
        busy_ok = 1'b1;
        do begin
            @(negedge clk);
            wait_n++;
        end while (bus.gnt == '0 && wait_n < 40);
        g = bus.gnt;
        if (g == '0) begin
            lat = -1;
            return;
        end
        if (!bus.busy) busy_ok = 1'b0;
        if (scramble) begin
            bus.req_data = {$urandom(), $urandom()};
            bus.req      = N_REQ'($urandom());
        end
        do begin
            @(negedge clk);
            lat++;
            if (!bus.busy) busy_ok = 1'b0;
        end while (!bus.done && lat < 40);
        id  = bus.done_id;
        cnt = bus.match_cnt;
`ifdef SEQ_DET_ARBITER_MATCH_MAP_EN
        obs_map = bus.match_map;
`endif
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        n_checks++; if (bus.gnt !== '0)       begin n_fail++; $display("FAIL reset_gnt: got %0h expected 0", bus.gnt); end
        n_checks++; if (bus.busy !== 1'b0)    begin n_fail++; $display("FAIL reset_busy: got %0b expected 0", bus.busy); end
        n_checks++; if (bus.done !== 1'b0)    begin n_fail++; $display("FAIL reset_done: got %0b expected 0", bus.done); end
        n_checks++; if (bus.done_id !== '0)   begin n_fail++; $display("FAIL reset_done_id: got %0d expected 0", bus.done_id); end
        n_checks++; if (bus.match_cnt !== '0) begin n_fail++; $display("FAIL reset_match_cnt: got %0d expected 0", bus.match_cnt); end
        rst_n = 1'b1;
        model_last = N_REQ - 1;
        repeat (2) @(negedge clk);
        n_checks++; if (bus.busy !== 1'b0)    begin n_fail++; $display("FAIL idle_busy: got %0b expected 0", bus.busy); end
    endtask

    task automatic test_back_to_back;
        logic [N_REQ-1:0] g;
        int wait_n, lat, exp_id;
        logic [ID_W-1:0] id;
        logic [CNT_W-1:0] cnt;
        bit busy_ok;
        for (int i = 0; i < N_REQ; i++) set_word(i, 16'hFFFF);
        bus.req = '1;
        for (int f = 0; f < 5; f++) begin
            exp_id = model_pick(bus.req, model_last);
            observe_frame(1'b0, g, wait_n, lat, id, cnt, busy_ok);
            n_checks++; if (g !== N_REQ'(1) << exp_id) begin n_fail++; $display("FAIL b2b_gnt[%0d]: got %0h expected %0h", f, g, N_REQ'(1) << exp_id); end
            n_checks++; if (id !== ID_W'(exp_id))       begin n_fail++; $display("FAIL b2b_done_id[%0d]: got %0d expected %0d", f, id, exp_id); end
            n_checks++; if (cnt !== '0)                 begin n_fail++; $display("FAIL b2b_cnt[%0d]: got %0d expected 0", f, cnt); end
            n_checks++; if (lat != FRAME_LEN)           begin n_fail++; $display("FAIL b2b_latency[%0d]: got %0d expected %0d", f, lat, FRAME_LEN); end
            n_checks++; if (wait_n != ((f == 0) ? 1 : 2)) begin n_fail++; $display("FAIL b2b_gap[%0d]: got %0d expected %0d", f, wait_n, (f == 0) ? 1 : 2); end
            n_checks++; if (!busy_ok)                   begin n_fail++; $display("FAIL b2b_busy[%0d]: got dropped expected held", f); end
            model_last = exp_id;
        end
        bus.req = '0;
        @(negedge clk);
        n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL b2b_done_pulse: got %0b expected 0", bus.done); end
        @(negedge clk);
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_busy: got %0b expected 0", bus.busy); end
    endtask

    task automatic test_vectors;
        logic [FRAME_LEN-1:0] vw [4];
        int vid [4];
        logic [N_REQ-1:0] g;
        int wait_n, lat, exp_cnt;
        logic [ID_W-1:0] id;
        logic [CNT_W-1:0] cnt;
        bit busy_ok;
        vw[0] = 16'b1101_1011_0110_0000; vid[0] = 0;
        vw[1] = 16'b0000_0000_0001_1011; vid[1] = 1;
        vw[2] = 16'b0000_0000_0000_1101; vid[2] = 3;
        vw[3] = 16'b1000_0000_0000_0000; vid[3] = 3;
        for (int v = 0; v < 4; v++) begin
            set_word(vid[v], vw[v]);
            bus.req = N_REQ'(1) << vid[v];
            exp_cnt = model_count(vw[v], CNT_W);
            observe_frame(1'b0, g, wait_n, lat, id, cnt, busy_ok);
            bus.req = '0;
            n_checks++; if (g !== N_REQ'(1) << vid[v]) begin n_fail++; $display("FAIL vec_gnt[%0d]: got %0h expected %0h", v, g, N_REQ'(1) << vid[v]); end
            n_checks++; if (id !== ID_W'(vid[v]))       begin n_fail++; $display("FAIL vec_done_id[%0d]: got %0d expected %0d", v, id, vid[v]); end
            n_checks++; if (cnt !== CNT_W'(exp_cnt))    begin n_fail++; $display("FAIL vec_cnt[%0d]: got %0d expected %0d", v, cnt, exp_cnt); end
            n_checks++; if (lat != FRAME_LEN)           begin n_fail++; $display("FAIL vec_latency[%0d]: got %0d expected %0d", v, lat, FRAME_LEN); end
            n_checks++; if (wait_n != 1)                begin n_fail++; $display("FAIL vec_wait[%0d]: got %0d expected 1", v, wait_n); end
            @(negedge clk);
            n_checks++; if (bus.done !== 1'b0)            begin n_fail++; $display("FAIL vec_done_once[%0d]: got %0b expected 0", v, bus.done); end
            n_checks++; if (bus.match_cnt !== CNT_W'(exp_cnt)) begin n_fail++; $display("FAIL vec_cnt_hold[%0d]: got %0d expected %0d", v, bus.match_cnt, exp_cnt); end
            model_last = vid[v];
        end
    endtask

    task automatic test_abort;
        logic [FRAME_LEN-1:0] w;
        logic [N_REQ-1:0] g;
        int n, wait_n, lat, exp_cnt;
        logic [ID_W-1:0] id;
        logic [CNT_W-1:0] cnt;
        bit busy_ok;
        w = 16'hDBDB;
        set_word(0, w);
        bus.req = 4'b0001;
        n = 0;
        do begin @(negedge clk); n++; end while (bus.gnt == '0 && n < 40);
        bus.req = '0;
        n_checks++; if (n != 1) begin n_fail++; $display("FAIL abort_gnt_wait: got %0d expected 1", n); end
        repeat (7) @(negedge clk);
        exp_cnt = model_count(w & 16'hFE00, CNT_W);
        n_checks++; if (bus.match_cnt !== CNT_W'(exp_cnt)) begin n_fail++; $display("FAIL abort_pre_cnt: got %0d expected %0d", bus.match_cnt, exp_cnt); end
        n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL abort_pre_busy: got %0b expected 1", bus.busy); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (bus.gnt !== '0)       begin n_fail++; $display("FAIL abort_gnt: got %0h expected 0", bus.gnt); end
        n_checks++; if (bus.busy !== 1'b0)    begin n_fail++; $display("FAIL abort_busy: got %0b expected 0", bus.busy); end
        n_checks++; if (bus.done !== 1'b0)    begin n_fail++; $display("FAIL abort_done: got %0b expected 0", bus.done); end
        n_checks++; if (bus.done_id !== '0)   begin n_fail++; $display("FAIL abort_done_id: got %0d expected 0", bus.done_id); end
        n_checks++; if (bus.match_cnt !== '0) begin n_fail++; $display("FAIL abort_match_cnt: got %0d expected 0", bus.match_cnt); end
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL abort_no_done[%0d]: got %0b expected 0", c, bus.done); end
        end
        model_last = N_REQ - 1;
        w = 16'($urandom()) | 16'h1B00;
        set_word(2, w);
        bus.req = 4'b0100;
        rst_n = 1'b1;
        observe_frame(1'b0, g, wait_n, lat, id, cnt, busy_ok);
        bus.req = '0;
        n_checks++; if (g !== 4'b0100)                           begin n_fail++; $display("FAIL abort_after_gnt: got %0h expected 4", g); end
        n_checks++; if (id !== ID_W'(2))                         begin n_fail++; $display("FAIL abort_after_id: got %0d expected 2", id); end
        n_checks++; if (cnt !== CNT_W'(model_count(w, CNT_W)))   begin n_fail++; $display("FAIL abort_after_cnt: got %0d expected %0d", cnt, model_count(w, CNT_W)); end
        model_last = 2;
    endtask

    task automatic test_saturate;
        logic [FRAME_LEN-1:0] w;
        logic [N_REQ-1:0] g;
        int wait_n, lat;
        logic [ID_W-1:0] id;
        logic [CNT_W-1:0] cnt;
        bit busy_ok;
        w = 16'b1101_1011_0110_1101;
        @(negedge clk);
        set_word(0, w);
        bus_sat.req_data = '0;
        bus_sat.req_data[FRAME_LEN-1:0] = w;
        bus.req     = 4'b0001;
        bus_sat.req = 4'b0001;
        observe_frame(1'b0, g, wait_n, lat, id, cnt, busy_ok);
        n_checks++; if (cnt !== CNT_W'(model_count(w, CNT_W))) begin n_fail++; $display("FAIL sat_wide_cnt: got %0d expected %0d", cnt, model_count(w, CNT_W)); end
        n_checks++; if (bus_sat.done !== 1'b1)                  begin n_fail++; $display("FAIL sat_done: got %0b expected 1", bus_sat.done); end
        n_checks++; if (bus_sat.match_cnt !== 2'(model_count(w, 2))) begin n_fail++; $display("FAIL sat_cnt: got %0d expected %0d", bus_sat.match_cnt, model_count(w, 2)); end
        bus.req     = '0;
        bus_sat.req = '0;
        model_last  = 0;
    endtask

    task automatic test_random;
        logic [N_REQ-1:0] r, g;
        logic [FRAME_LEN-1:0] w;
        int wait_n, lat, exp_id, exp_cnt;
        logic [ID_W-1:0] id;
        logic [CNT_W-1:0] cnt;
        bit busy_ok;
        @(negedge clk);
        for (int f = 0; f < 24; f++) begin
            do r = N_REQ'($urandom()); while (r == '0);
            for (int i = 0; i < N_REQ; i++) begin
                w = ($urandom_range(0, 1) != 0) ? 16'($urandom())
                                                : (16'hDB6D ^ (16'h1 << $urandom_range(0, 15)));
                set_word(i, w);
            end
            bus.req = r;
            exp_id  = model_pick(r, model_last);
            exp_cnt = model_count(get_word(exp_id), CNT_W);
            observe_frame(1'b1, g, wait_n, lat, id, cnt, busy_ok);
            n_checks++; if (g !== N_REQ'(1) << exp_id)  begin n_fail++; $display("FAIL rnd_gnt[%0d]: got %0h expected %0h", f, g, N_REQ'(1) << exp_id); end
            n_checks++; if (id !== ID_W'(exp_id))        begin n_fail++; $display("FAIL rnd_done_id[%0d]: got %0d expected %0d", f, id, exp_id); end
            n_checks++; if (cnt !== CNT_W'(exp_cnt))     begin n_fail++; $display("FAIL rnd_cnt[%0d]: got %0d expected %0d", f, cnt, exp_cnt); end
            n_checks++; if (lat != FRAME_LEN)            begin n_fail++; $display("FAIL rnd_latency[%0d]: got %0d expected %0d", f, lat, FRAME_LEN); end
            n_checks++; if (wait_n != ((f == 0) ? 1 : 2)) begin n_fail++; $display("FAIL rnd_gap[%0d]: got %0d expected %0d", f, wait_n, (f == 0) ? 1 : 2); end
            model_last = exp_id;
        end
        bus.req = '0;
        @(negedge clk);
    endtask

`ifdef SEQ_DET_ARBITER_MATCH_MAP_EN
    task automatic test_match_map;
        logic [FRAME_LEN-1:0] w;
        logic [N_REQ-1:0] g;
        int wait_n, lat;
        logic [ID_W-1:0] id;
        logic [CNT_W-1:0] cnt;
        bit busy_ok;
        for (int t = 0; t < 4; t++) begin
            w = (t == 0) ? 16'b1101_1000_0000_0000 : (16'($urandom()) | 16'h1B1B);
            set_word(1, w);
            bus.req = 4'b0010;
            observe_frame(1'b0, g, wait_n, lat, id, cnt, busy_ok);
            bus.req = '0;
            n_checks++; if (obs_map !== model_map(w))            begin n_fail++; $display("FAIL map[%0d]: got %0h expected %0h", t, obs_map, model_map(w)); end
            n_checks++; if (cnt !== CNT_W'(model_count(w, CNT_W))) begin n_fail++; $display("FAIL map_cnt[%0d]: got %0d expected %0d", t, cnt, model_count(w, CNT_W)); end
            @(negedge clk);
        end
        model_last = 1;
    endtask
`endif

    initial begin
        bus.req          = '0;
        bus.req_data     = '0;
        bus_sat.req      = '0;
        bus_sat.req_data = '0;
        model_last       = N_REQ - 1;
        test_reset();
        test_back_to_back();
        test_vectors();
        test_abort();
        test_saturate();
        test_random();
`ifdef SEQ_DET_ARBITER_MATCH_MAP_EN
        test_match_map();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
